// File: rtl/l1_request_arbiter_pkg.sv
// Shared L1 port configuration: requester IDs, connection count, read cap and request record.
package l1_request_arbiter_pkg;

  localparam int L1_CONNECTIONS     = 4;
  localparam int MAX_INFLIGHT_COUNT = 4;
  localparam int L1_SIZE_W          = 5;

  localparam int L1_DCACHE_ID = 0;
  localparam int L1_DMMU_ID   = 1;
  localparam int L1_ICACHE_ID = 2;
  localparam int L1_IMMU_ID   = 3;

  typedef logic [$clog2(L1_CONNECTIONS)-1:0] l1_id_t;

  typedef struct packed {
    logic [31:0]          addr;
    logic                 rnw;
    logic [3:0]           be;
    logic [31:0]          wdata;
    logic [L1_SIZE_W-1:0] size;
  } l1_request_t;

endpackage

// File: rtl/l1_rr_picker.sv
// Rotating-priority encoder: the first set request after rr_ptr (wrapping) wins.
module l1_rr_picker #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_vec_i,
  input  logic [IW-1:0] rr_ptr_i,
  output logic          valid_o,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int j;

  // Scan from farthest to nearest so the nearest candidate overwrites and wins.
  always_comb begin
    valid_o = 1'b0;
    grant_o = '0;
    idx_o   = '0;
    j       = 0;
    for (int k = N; k >= 1; k--) begin
      j = (int'(rr_ptr_i) + k) % N;
      if (req_vec_i[j]) begin
        valid_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
    if (valid_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/l1_request_arbiter.sv
// Round-robin arbiter sharing the L1 memory port, with a registered request slice,
// an outstanding-read cap and tag-based read-beat routing.
module l1_request_arbiter
  import l1_request_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = L1_CONNECTIONS,
  parameter  int MAX_READS = MAX_INFLIGHT_COUNT,
  parameter  int SIZE_W    = L1_SIZE_W,
  localparam int IW        = $clog2(NUM_REQ),
  localparam int CW        = $clog2(MAX_READS + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0][31:0]       req_addr,
  input  logic [NUM_REQ-1:0]             req_rnw,
  input  logic [NUM_REQ-1:0][3:0]        req_be,
  input  logic [NUM_REQ-1:0][31:0]       req_wdata,
  input  logic [NUM_REQ-1:0][SIZE_W-1:0] req_size,
  output logic [NUM_REQ-1:0]             req_ack,
  output logic                           mem_request,
  output logic [31:0]                    mem_addr,
  output logic                           mem_rnw,
  output logic [3:0]                     mem_be,
  output logic [31:0]                    mem_wdata,
  output logic [SIZE_W-1:0]              mem_size,
  output logic [IW-1:0]                  mem_id,
  input  logic                           mem_ack,
  input  logic                           mem_rd_valid,
  input  logic [IW-1:0]                  mem_rd_id,
  input  logic                           mem_rd_last,
  input  logic [31:0]                    mem_rd_data,
  output logic [NUM_REQ-1:0]             rd_valid,
  output logic [31:0]                    rd_data
);

  logic              mem_request_q, mem_request_d;
  logic [31:0]       mem_addr_q,    mem_addr_d;
  logic              mem_rnw_q,     mem_rnw_d;
  logic [3:0]        mem_be_q,      mem_be_d;
  logic [31:0]       mem_wdata_q,   mem_wdata_d;
  logic [SIZE_W-1:0] mem_size_q,    mem_size_d;
  logic [IW-1:0]     mem_id_q,      mem_id_d;
  logic [IW-1:0]     rr_ptr_q,      rr_ptr_d;
  logic [CW-1:0]     read_count_q,  read_count_d;

  logic               slice_free;
  logic               slice_rd;
  logic               read_ok;
  logic               load;
  logic               count_inc;
  logic               count_dec;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic               pick_valid;
  logic [IW-1:0]      pick_idx;

  assign slice_free = !mem_request_q || mem_ack;
  // A read still parked in the slice already counts against the cap.
  assign slice_rd   = mem_request_q && mem_rnw_q;
  assign read_ok    = ({1'b0, read_count_q} + {{CW{1'b0}}, slice_rd}) < (CW+1)'(MAX_READS);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign eligible[gi] = req[gi] && (!req_rnw[gi] || read_ok);
      assign rd_valid[gi] = !rst && mem_rd_valid && (mem_rd_id == IW'(gi));
    end
  endgenerate

  l1_rr_picker #(.N(NUM_REQ)) u_picker (
    .req_vec_i (eligible),
    .rr_ptr_i  (rr_ptr_q),
    .valid_o   (pick_valid),
    .grant_o   (grant),
    .idx_o     (pick_idx)
  );

  assign load      = !rst && slice_free && pick_valid;
  assign req_ack   = load ? grant : '0;
  assign count_inc = mem_request_q && mem_ack && mem_rnw_q;
  assign count_dec = mem_rd_valid && mem_rd_last;

  always_comb begin
    mem_request_d = mem_request_q;
    mem_addr_d    = mem_addr_q;
    mem_rnw_d     = mem_rnw_q;
    mem_be_d      = mem_be_q;
    mem_wdata_d   = mem_wdata_q;
    mem_size_d    = mem_size_q;
    mem_id_d      = mem_id_q;
    rr_ptr_d      = rr_ptr_q;
    read_count_d  = read_count_q;

    if (load) begin
      mem_request_d = 1'b1;
      mem_addr_d    = req_addr[pick_idx];
      mem_rnw_d     = req_rnw[pick_idx];
      mem_be_d      = req_be[pick_idx];
      mem_wdata_d   = req_wdata[pick_idx];
      mem_size_d    = req_size[pick_idx];
      mem_id_d      = pick_idx;
      rr_ptr_d      = pick_idx;
    end else if (mem_ack) begin
      mem_request_d = 1'b0;
    end

    if (count_inc && !count_dec) read_count_d = read_count_q + CW'(1);
    else if (count_dec && !count_inc) read_count_d = read_count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_request_q <= 1'b0;
      mem_addr_q    <= '0;
      mem_rnw_q     <= 1'b0;
      mem_be_q      <= '0;
      mem_wdata_q   <= '0;
      mem_size_q    <= '0;
      mem_id_q      <= '0;
      rr_ptr_q      <= IW'(NUM_REQ - 1);
      read_count_q  <= '0;
    end else begin
      mem_request_q <= mem_request_d;
      mem_addr_q    <= mem_addr_d;
      mem_rnw_q     <= mem_rnw_d;
      mem_be_q      <= mem_be_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_size_q    <= mem_size_d;
      mem_id_q      <= mem_id_d;
      rr_ptr_q      <= rr_ptr_d;
      read_count_q  <= read_count_d;
    end
  end

  assign mem_request = mem_request_q;
  assign mem_addr    = mem_addr_q;
  assign mem_rnw     = mem_rnw_q;
  assign mem_be      = mem_be_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_size    = mem_size_q;
  assign mem_id      = mem_id_q;
  assign rd_data     = mem_rd_data;

  a_count_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (count_dec && !count_inc) |-> (read_count_q != '0));
  a_count_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (count_inc && !count_dec) |-> (int'(read_count_q) < MAX_READS));
  a_rd_id_in_range: assert property (@(posedge clk) disable iff (rst)
    mem_rd_valid |-> (int'(mem_rd_id) < NUM_REQ));

endmodule

// File: tb/tb_l1_request_arbiter.sv
// Randomized and directed bench for l1_request_arbiter against a queue-based reference model.
module tb_l1_request_arbiter;

  localparam int N    = 4;
  localparam int MAXR = 4;
  localparam int SW   = 5;
  localparam int IW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic [N-1:0]               req;
  logic [N-1:0][31:0]         req_addr;
  logic [N-1:0]               req_rnw;
  logic [N-1:0][3:0]          req_be;
  logic [N-1:0][31:0]         req_wdata;
  logic [N-1:0][SW-1:0]       req_size;
  logic [N-1:0]               req_ack;
  logic                       mem_request;
  logic [31:0]                mem_addr;
  logic                       mem_rnw;
  logic [3:0]                 mem_be;
  logic [31:0]                mem_wdata;
  logic [SW-1:0]              mem_size;
  logic [IW-1:0]              mem_id;
  logic                       mem_ack;
  logic                       mem_rd_valid;
  logic [IW-1:0]              mem_rd_id;
  logic                       mem_rd_last;
  logic [31:0]                mem_rd_data;
  logic [N-1:0]               rd_valid;
  logic [31:0]                rd_data;

  l1_request_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_addr     (req_addr),
    .req_rnw      (req_rnw),
    .req_be       (req_be),
    .req_wdata    (req_wdata),
    .req_size     (req_size),
    .req_ack      (req_ack),
    .mem_request  (mem_request),
    .mem_addr     (mem_addr),
    .mem_rnw      (mem_rnw),
    .mem_be       (mem_be),
    .mem_wdata    (mem_wdata),
    .mem_size     (mem_size),
    .mem_id       (mem_id),
    .mem_ack      (mem_ack),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_id    (mem_rd_id),
    .mem_rd_last  (mem_rd_last),
    .mem_rd_data  (mem_rd_data),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data)
  );

  typedef struct {
    logic [31:0]   addr;
    logic          rnw;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic [SW-1:0] size;
  } rq_t;

  typedef struct {
    int id;
    int left;
  } burst_t;

  // Requester-side intent, slice contents and the set of reads the memory still owes.
  rq_t    pend_rq [N];
  bit     pend    [N];
  bit     sl_valid;
  bit     sl_zero;
  bit     inited;
  rq_t    sl_rq;
  int     sl_id;
  int     rr;
  burst_t mem_q[$];

  bit rst_v, mem_ack_v, beat_en;
  int n_checks, n_fail, cyc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic new_req(input int i, input bit rnw, input logic [31:0] addr, input int size);
    pend[i]          = 1'b1;
    pend_rq[i].addr  = addr & 32'hFFFF_FFFC;
    pend_rq[i].rnw   = rnw;
    pend_rq[i].be    = 4'($urandom);
    pend_rq[i].wdata = $urandom;
    pend_rq[i].size  = SW'(size);
  endtask

  task automatic step();
    bit            ok, beat, last;
    int            win, best, d, outstanding;
    logic [N-1:0]  exp_ack, exp_rv;
    logic [IW-1:0] sid;

    @(negedge clk);
    rst = rst_v;
    for (int i = 0; i < N; i++) begin
      req[i]       = pend[i];
      req_addr[i]  = pend_rq[i].addr;
      req_rnw[i]   = pend_rq[i].rnw;
      req_be[i]    = pend_rq[i].be;
      req_wdata[i] = pend_rq[i].wdata;
      req_size[i]  = pend_rq[i].size;
    end
    mem_ack      = mem_ack_v;
    beat         = beat_en && (mem_q.size() > 0);
    last         = beat && (mem_q[0].left == 1);
    mem_rd_valid = beat;
    mem_rd_id    = beat ? IW'(mem_q[0].id) : IW'($urandom);
    mem_rd_last  = beat ? last : 1'($urandom);
    mem_rd_data  = $urandom;
    #1;

    // Winner: eligible requester nearest after the last winner, going round the ring.
    outstanding = mem_q.size() + ((sl_valid && sl_rq.rnw) ? 1 : 0);
    ok   = outstanding < MAXR;
    win  = -1;
    best = N;
    for (int i = 0; i < N; i++) begin
      if (pend[i] && (!pend_rq[i].rnw || ok)) begin
        d = (i - rr - 1 + 2 * N) % N;
        if (d < best) begin
          best = d;
          win  = i;
        end
      end
    end
    if (rst_v || (sl_valid && !mem_ack_v)) win = -1;
    exp_ack = '0;
    if (win >= 0) exp_ack[win] = 1'b1;
    exp_rv = '0;
    if (beat && !rst_v) exp_rv[mem_q[0].id] = 1'b1;

    check_eq("req_ack", 128'(req_ack), 128'(exp_ack));
    check_eq("rd_valid", 128'(rd_valid), 128'(exp_rv));
    check_eq("rd_data", 128'(rd_data), 128'(mem_rd_data));
    if (inited) begin
      check_eq("mem_request", 128'(mem_request), 128'(sl_valid));
      if (sl_valid) begin
        sid = IW'(sl_id);
        check_eq("slice", 128'({mem_addr, mem_rnw, mem_be, mem_wdata, mem_size, mem_id}),
                 128'({sl_rq.addr, sl_rq.rnw, sl_rq.be, sl_rq.wdata, sl_rq.size, sid}));
      end
      if (sl_zero)
        check_eq("slice_reset", 128'({mem_addr, mem_rnw, mem_be, mem_wdata, mem_size, mem_id}), 128'(0));
    end

    if (rst_v) begin
      sl_valid = 1'b0;
      sl_zero  = 1'b1;
      inited   = 1'b1;
      rr       = N - 1;
      mem_q.delete();
    end else begin
      if (beat) begin
        mem_q[0].left--;
        if (mem_q[0].left == 0) void'(mem_q.pop_front());
      end
      if (sl_valid && mem_ack_v && sl_rq.rnw)
        mem_q.push_back('{id: sl_id, left: int'(sl_rq.size) + 1});
      if (win >= 0) begin
        $display("cycle %0d: ack id %0d %s addr %08h size %0d", cyc, win,
                 pend_rq[win].rnw ? "read " : "write", pend_rq[win].addr, pend_rq[win].size);
        sl_valid = 1'b1;
        sl_zero  = 1'b0;
        sl_rq    = pend_rq[win];
        sl_id    = win;
        rr       = win;
        pend[win] = 1'b0;
      end else if (mem_ack_v) begin
        sl_valid = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    sl_valid = 0; sl_zero = 0; inited = 0; sl_id = 0; rr = N - 1;
    sl_rq = '{addr: 0, rnw: 0, be: 0, wdata: 0, size: 0};
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pend_rq[i] = '{addr: 0, rnw: 0, be: 0, wdata: 0, size: 0};
    end

    // Reset with a request already pending: no ack while rst is high.
    rst_v = 1; mem_ack_v = 0; beat_en = 0;
    new_req(1, 0, 32'h1000, 0);
    repeat (2) step();
    rst_v = 0;
    clear_reqs();

    // Single read burst from ICACHE.
    new_req(2, 1, 32'h4000_0100, 3);
    mem_ack_v = 1;
    repeat (2) step();
    beat_en = 1;
    repeat (5) step();
    beat_en = 0;

    // Four requesters issuing writes continuously.
    repeat (12) begin
      for (int i = 0; i < N; i++) if (!pend[i]) new_req(i, 0, $urandom, 0);
      step();
    end
    clear_reqs();
    step();

    // Backpressure on a loaded slice with id 1 waiting.
    new_req(0, 0, $urandom, 0);
    step();
    mem_ack_v = 0;
    new_req(1, 0, $urandom, 0);
    repeat (5) step();
    mem_ack_v = 1;
    repeat (2) step();

    // Read cap: four reads outstanding, then a fifth read and a write.
    for (int i = 0; i < N; i++) new_req(i, 1, $urandom, 0);
    repeat (6) step();
    new_req(0, 1, $urandom, 0);
    new_req(3, 0, $urandom, 0);
    repeat (3) step();
    beat_en = 1;
    step();
    beat_en = 0;
    repeat (3) step();
    beat_en = 1;
    repeat (6) step();
    beat_en = 0;

    // Accept a read and retire one in the same cycle with two outstanding.
    new_req(0, 1, $urandom, 0);
    new_req(1, 1, $urandom, 0);
    repeat (4) step();
    new_req(2, 1, $urandom, 0);
    step();
    beat_en = 1;
    step();
    beat_en = 0;
    for (int i = 0; i < N; i++) new_req(i, 1, $urandom, 0);
    repeat (6) step();
    clear_reqs();

    // Reset while a read waits in the slice.
    mem_ack_v = 0;
    new_req(3, 1, $urandom, 1);
    step();
    rst_v = 1;
    beat_en = 1;
    step();
    rst_v = 0;
    beat_en = 0;
    clear_reqs();
    new_req(1, 0, $urandom, 0);
    new_req(0, 0, $urandom, 0);
    mem_ack_v = 1;
    repeat (3) step();

    // Random traffic with alternating slow and fast response phases.
    for (int t = 0; t < 1500; t++) begin
      rst_v     = ($urandom_range(0, 399) == 0);
      mem_ack_v = ($urandom_range(0, 9) < 7);
      beat_en   = ($urandom_range(0, 9) < (((t / 200) % 2 == 1) ? 2 : 7));
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if ($urandom_range(0, 24) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          new_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
